// File: rtl/rx_chnl_data_packer.sv
`default_nettype none
// ============================================================================
// Module      : rx_chnl_data_packer
// Description : Packs sparse lower-justified engine words into dense FIFO words,
//               flushes a padded tail word and reports transfer status.
// Revision    : 1.0
// ============================================================================
module rx_chnl_data_packer #(
    parameter int C_PCI_DATA_WIDTH       = 128,
    parameter int C_PCI_DATA_WORD        = C_PCI_DATA_WIDTH / 32,
    parameter int C_PCI_DATA_COUNT_WIDTH = $clog2(C_PCI_DATA_WORD + 1),
    parameter int C_WORD_COUNT_WIDTH     = 32
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [C_PCI_DATA_WIDTH-1:0]       i_data,
    input  logic [C_PCI_DATA_COUNT_WIDTH-1:0] i_data_en,
    input  logic                              i_done,
    input  logic                              i_err,
    output logic [C_PCI_DATA_WIDTH-1:0]       o_fifo_data,
    output logic                              o_fifo_wen,
    output logic [C_PCI_DATA_COUNT_WIDTH-1:0] o_fifo_count,
    input  logic                              i_fifo_full,
    output logic [C_WORD_COUNT_WIDTH-1:0]     o_words_recvd,
    output logic                              o_xfer_done,
    output logic                              o_xfer_err,
    output logic                              o_overflow,
    output logic                              o_proto_err
);

    localparam int DW = C_PCI_DATA_WIDTH;
    localparam int CW = C_PCI_DATA_COUNT_WIDTH;
    localparam int WC = C_WORD_COUNT_WIDTH;

    localparam logic [CW:0]   c_full_words = (CW+1)'(C_PCI_DATA_WORD);
    localparam logic [CW-1:0] c_full_cnt   = CW'(C_PCI_DATA_WORD);

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]    r_state;
    logic [DW-1:0] r_resid;
    logic [CW-1:0] r_rcnt;
    logic          r_err_lat;
    logic          r_fresh;
    logic [DW-1:0] r_fdata;
    logic [CW-1:0] r_fcount;
    logic          r_wen;
    logic [WC-1:0] r_words;
    logic          r_xdone;
    logic          r_xerr;
    logic          r_overflow;
    logic          r_proto;

    logic [DW-1:0]   w_data_m;
    logic [2*DW-1:0] w_comb;
    logic [CW:0]     w_total;
    logic            w_emit;
    logic [CW-1:0]   w_rnext;
    logic [DW-1:0]   w_resid_next;
    logic [WC:0]     w_words_sum;
    logic [WC-1:0]   w_words_sat;

    // Zero the words above DATA_EN so the residual never carries stale data.
    for (genvar gi = 0; gi < C_PCI_DATA_WORD; gi++) begin : g_mask
        assign w_data_m[gi*32 +: 32] = (CW'(gi) < i_data_en) ? i_data[gi*32 +: 32] : 32'd0;
    end

    assign w_comb       = ({{DW{1'b0}}, w_data_m} << {r_rcnt, 5'b00000}) | {{DW{1'b0}}, r_resid};
    assign w_total      = {1'b0, r_rcnt} + {1'b0, i_data_en};
    assign w_emit       = (w_total >= c_full_words);
    assign w_rnext      = CW'(w_emit ? (w_total - c_full_words) : w_total);
    assign w_resid_next = w_emit ? w_comb[2*DW-1:DW] : w_comb[DW-1:0];
    assign w_words_sum  = {1'b0, r_words} + (WC+1)'(i_data_en);
    assign w_words_sat  = w_words_sum[WC] ? {WC{1'b1}} : w_words_sum[WC-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_ACCUM;
            r_resid    <= '0;
            r_rcnt     <= '0;
            r_err_lat  <= 1'b0;
            r_fresh    <= 1'b0;
            r_fdata    <= '0;
            r_fcount   <= '0;
            r_wen      <= 1'b0;
            r_words    <= '0;
            r_xdone    <= 1'b0;
            r_xerr     <= 1'b0;
            r_overflow <= 1'b0;
            r_proto    <= 1'b0;
        end else begin
            r_wen   <= 1'b0;
            r_xdone <= 1'b0;
            r_xerr  <= 1'b0;
            if (r_state == S_ACCUM) begin
                r_resid <= w_resid_next;
                r_rcnt  <= w_rnext;
                if (w_emit) begin
                    if (i_fifo_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wen    <= 1'b1;
                        r_fdata  <= w_comb[DW-1:0];
                        r_fcount <= c_full_cnt;
                    end
                end
                if (i_data_en != '0) begin
                    r_words <= r_fresh ? WC'(i_data_en) : w_words_sat;
                    r_fresh <= 1'b0;
                end
                // A leftover partial word defers completion to the flush cycle.
                if (i_done) begin
                    if (w_rnext != '0) begin
                        r_state   <= S_FLUSH;
                        r_err_lat <= i_err;
                    end else begin
                        r_xdone <= 1'b1;
                        r_xerr  <= i_err;
                        r_fresh <= 1'b1;
                    end
                end
            end else begin
                if (i_fifo_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wen    <= 1'b1;
                    r_fdata  <= r_resid;
                    r_fcount <= r_rcnt;
                end
                if (i_data_en != '0) begin
                    r_proto <= 1'b1;
                end
                r_xdone <= 1'b1;
                r_xerr  <= r_err_lat;
                r_fresh <= 1'b1;
                r_resid <= '0;
                r_rcnt  <= '0;
                r_state <= S_ACCUM;
            end
        end
    end

    assign o_fifo_data   = r_fdata;
    assign o_fifo_wen    = r_wen;
    assign o_fifo_count  = r_fcount;
    assign o_words_recvd = r_words;
    assign o_xfer_done   = r_xdone;
    assign o_xfer_err    = r_xerr;
    assign o_overflow    = r_overflow;
    assign o_proto_err   = r_proto;

endmodule
`default_nettype wire

// File: doc/rx_chnl_data_packer.md
Name: rx_chnl_data_packer

Overview:
- Per-channel stage directly downstream of the completion reorder stage.
- Consumes that channel's in-order ENG_DATA stream plus its per-cycle valid-word count, DONE and ERR.
- Repacks the sparse, lower-justified words into dense full-width words for the channel RX FIFO.
- Flushes a padded partial word at end of transfer and reports word totals and error status to the channel controller.

Parameters:
- C_PCI_DATA_WIDTH, 128, datapath width in bits (64 or 128 supported).
- C_PCI_DATA_WORD, C_PCI_DATA_WIDTH/32, 32-bit words per beat (derived).
- C_PCI_DATA_COUNT_WIDTH, clog2(C_PCI_DATA_WORD+1), width of word-count fields (derived).
- C_WORD_COUNT_WIDTH, 32, width of the transfer word counter.

Ports:
- CLK  input  1  clock.
- RST_N  input  1  asynchronous active-low reset.
- DATA  input  C_PCI_DATA_WIDTH  engine data; valid words lower-justified, word 0 in bits [31:0].
- DATA_EN  input  C_PCI_DATA_COUNT_WIDTH  number of valid words in DATA this cycle (0..C_PCI_DATA_WORD).
- DONE  input  1  transfer complete; may coincide with the last DATA_EN.
- ERR  input  1  transfer completed with error; qualified by DONE.
- FIFO_DATA  output  C_PCI_DATA_WIDTH  packed write data.
- FIFO_WEN  output  1  write strobe to channel FIFO.
- FIFO_COUNT  output  C_PCI_DATA_COUNT_WIDTH  valid words in FIFO_DATA; full width except the last word.
- FIFO_FULL  input  1  FIFO cannot accept a write this cycle.
- WORDS_RECVD  output  C_WORD_COUNT_WIDTH  words accepted in the current or last transfer.
- XFER_DONE  output  1  one-cycle pulse with the final write of a transfer.
- XFER_ERR  output  1  one-cycle pulse with XFER_DONE when ERR was seen.
- OVERFLOW  output  1  sticky: a write was dropped because FIFO_FULL was high.
- PROTO_ERR  output  1  sticky: DATA_EN nonzero during FLUSH.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Residual register and residual count cleared; state ACCUM.
  - All outputs 0, including FIFO_DATA, WORDS_RECVD and the sticky flags.
- Input interface has no backpressure: every DATA_EN word must be absorbed in the cycle it is presented.
- Combining:
  - Per cycle, combined = {DATA words, residual words}, with the new words placed directly above the R residual words.
  - Total T = R + DATA_EN, range 0..2*C_PCI_DATA_WORD-1.
- Full-word emission:
  - If T >= C_PCI_DATA_WORD, the lower C_PCI_DATA_WORD words are written next cycle (registered, latency 1), with FIFO_COUNT = C_PCI_DATA_WORD.
  - New residual = the upper T-C_PCI_DATA_WORD words.
  - Otherwise no write and residual = combined, R = T.
- States:
  - ACCUM: normal packing. On DONE:
    - Go to FLUSH if residual after this cycle's packing is nonzero.
    - Otherwise XFER_DONE/XFER_ERR assert next cycle, together with the full word if one was emitted.
    - If DONE arrives with no word emitted and R=0, XFER_DONE asserts alone with FIFO_WEN=0.
  - FLUSH (one cycle): emit residual as FIFO_DATA with upper unused words zero.
    - FIFO_COUNT = R; XFER_DONE (and XFER_ERR if latched) pulse with this write.
    - Then clear residual and return to ACCUM.
    - DATA_EN nonzero in FLUSH: those words are dropped and PROTO_ERR sets.
- ERR is latched when DONE is high and reported only with XFER_DONE. ERR without DONE is ignored.
- WORDS_RECVD:
  - Adds DATA_EN each cycle, saturating at all-ones.
  - Holds its final value after XFER_DONE.
  - Resets to DATA_EN on the first nonzero DATA_EN following XFER_DONE.
- Overflow:
  - If a write is due while FIFO_FULL is high, FIFO_WEN stays 0, the word is lost and OVERFLOW sets.
  - Packing state still advances.
  - XFER_DONE still pulses on a dropped final write.
- FIFO_DATA holds its last value when FIFO_WEN=0.
- DONE together with DATA_EN=0 is legal.

Test Plan:
- 128-bit. DATA_EN=4 for 3 cycles (words 0..11), DONE with the last beat:
  - 3 writes, each FIFO_COUNT=4, words in order.
  - XFER_DONE with the 3rd write; WORDS_RECVD=12; no FLUSH.
- DATA_EN sequence 3,3,3 with DONE on the 3rd beat:
  - Writes: words 0-3, then words 4-7.
  - Then FLUSH write with word 8 in [31:0], zeros above, FIFO_COUNT=1, XFER_DONE.
  - WORDS_RECVD=9.
- DATA_EN=1 x 2 cycles, DONE with ERR=1:
  - Single FLUSH write with FIFO_COUNT=2; XFER_DONE=XFER_ERR=1 for one cycle.
- FIFO_FULL high during the 2nd full write of a 12-word transfer:
  - That word is not written; OVERFLOW=1 and stays 1.
  - 3rd word is still written with XFER_DONE.
- DATA_EN=2 during FLUSH:
  - PROTO_ERR=1, words not counted, next transfer starts clean.
- RST_N pulsed low mid-transfer with R=3:
  - All outputs 0 immediately (asynchronously).
  - After release, a 4-word beat writes exactly those 4 new words.
